vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Single-port scheduler for the frame-buffer BRAM in the camera-to-HDMI path. One RAM port is shared by two requesters.
- Capture requester: words arrive from the CMOS-side CDC FIFO and are written into VRAM.
- Display requester: bursts are read from VRAM into the pixel-side CDC FIFO.
- The block owns both frame address counters and handles frame-start resynchronisation, fairness and error flagging.

Parameters:
ADDR_W, 17, VRAM address width
DATA_W, 12, pixel width (RGB444)
FRAME_PIXELS, 76800, words per frame (320x240); addresses wrap at FRAME_PIXELS-1
RD_BURST, 8, reads issued per display grant
WR_RUN, 16, max words per capture grant
STARVE_MAX, 4, consecutive read grants allowed while capture data waits

Ports:
sys_clk_pin  in  1  clock (100 MHz)
reset  in  1  synchronous, active-high
cap_empty  in  1  capture FIFO empty (first-word-fall-through)
cap_full  in  1  capture FIFO full
cap_data  in  DATA_W  capture FIFO head word
cap_rd  out  1  pop capture FIFO
cap_frame_start  in  1  one-cycle pulse, sys_clk_pin domain, new camera frame
disp_almost_full  in  1  display FIFO cannot accept RD_BURST more words
disp_frame_start  in  1  one-cycle pulse, display vsync resynchronised
disp_wr  out  1  push to display FIFO
disp_data  out  DATA_W  display FIFO write data
ram_en  out  1  RAM port enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_dout  in  DATA_W  RAM read data, valid 1 cycle after read issue
frame_done  out  1  one-cycle pulse when rd_addr wraps to 0
overflow_err  out  1  sticky capture-overflow flag

Behaviour:
- Reset: state=IDLE, wr_addr=rd_addr=0, starve=0, pending flags=0. All outputs 0 (cap_rd, disp_wr, ram_en, ram_we, ram_addr, ram_din, disp_data, frame_done, overflow_err).
- States: IDLE, WRITE, READ, DRAIN.
- Read eligible (rd_ok) = !disp_almost_full.
- Capture pending (cap_ok) = !cap_empty.
- IDLE arbitration, one decision per cycle:
  - rd_ok && (!cap_ok || starve<STARVE_MAX) -> READ; starve += cap_ok (saturating).
  - else cap_ok -> WRITE; starve=0.
  - else stay IDLE.
- WRITE, each cycle while cap_ok:
  - ram_en=ram_we=1, ram_addr=wr_addr, ram_din=cap_data, cap_rd=1.
  - wr_addr wraps at FRAME_PIXELS-1.
  - Exit to IDLE when cap_empty, or after WR_RUN words (the exit cycle issues no write).
- READ: RD_BURST consecutive cycles of ram_en=1, ram_we=0, ram_addr=rd_addr, rd_addr incrementing with wrap. Then DRAIN for one cycle, then IDLE.
- disp_wr/disp_data: registered, one cycle after each read issue, so disp_wr forms a contiguous RD_BURST-cycle pulse train offset by 1 (latest in DRAIN).
- Bursts are never interrupted. disp_almost_full rising mid-burst is ignored; the FIFO threshold guarantees room.
- frame_done: pulses in the cycle rd_addr wraps FRAME_PIXELS-1 -> 0.
- cap_frame_start:
  - Sets wr_addr=0 next cycle.
  - If coincident with a write, that write uses the old address and its increment is discarded.
- disp_frame_start:
  - Latched in disp_pend.
  - At the next READ entry, rd_addr is forced to 0 before the first issue and disp_pend is cleared. The burst in flight keeps its addresses.
- overflow_err: set when cap_full=1 while state!=WRITE; cleared only by reset.
- Simultaneous cap_frame_start and wr_addr wrap: result is 0.
- Reset asserted mid-burst: outputs return to 0 the next cycle; no further disp_wr.

Decomposition:
- Package vram_arb_pkg holds:
  - state_t enum (IDLE, WRITE, READ, DRAIN)
  - default FRAME_PIXELS, RD_BURST, WR_RUN, STARVE_MAX constants
  - pixel_t typedef (logic [DATA_W-1:0])
- One sub-module, frame_addr_ctr. It is instantiated twice (write and read address) and provides:
  - increment enable
  - synchronous clear
  - wrap at FRAME_PIXELS-1
  - wrap pulse output

Test Plan:
- Reset, then cap_empty=0 with data 0x123 and disp_almost_full=1 -> WRITE one cycle later. Addresses 0..15 are written with cap_rd high for 16 cycles, then IDLE.
- cap_empty=1, disp_almost_full=0 -> ram_addr 0..7 with ram_we=0. disp_wr is high for 8 cycles starting 1 cycle after the first issue, and disp_data equals the RAM model contents.
- Both requesters always ready -> exactly 4 read bursts, then 1 write grant, repeating. No write is starved longer than 4*(RD_BURST+2) cycles.
- Preload rd_addr=76792 and run one burst -> addresses 76792..76799 are read. frame_done pulses at the wrap, and the next burst starts at 0.
- disp_frame_start mid-burst at rd_addr=100 -> the burst completes through 107 and the next burst starts at 0. cap_frame_start during WRITE at wr_addr=50 -> that write goes to 50, the next write goes to 0.
- cap_full=1 while in READ -> overflow_err=1 and stays 1 after cap_full drops. Reset clears it.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// ---------------------------------------------------------------------------
// vram_arb_pkg
// Shared types and default sizing for the frame-buffer VRAM arbiter.
//   state_t       : arbiter FSM states
//   *_DEF         : default geometry / fairness constants (320x240 RGB444)
//   pixel_t       : one frame-buffer word at the default pixel width
// ---------------------------------------------------------------------------
package vram_arb_pkg;

    localparam int ADDR_W_DEF       = 17;
    localparam int DATA_W_DEF       = 12;
    localparam int FRAME_PIXELS_DEF = 76800;
    localparam int RD_BURST_DEF     = 8;
    localparam int WR_RUN_DEF       = 16;
    localparam int STARVE_MAX_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef logic [DATA_W_DEF-1:0] pixel_t;

endpackage

// File: rtl/vram_arbiter_addr_ctr.sv
// ---------------------------------------------------------------------------
// frame_addr_ctr
// Frame address counter: increments on inc_i, wraps FRAME_PIXELS-1 -> 0,
// synchronous clear (clear beats increment, so a coincident increment is
// discarded and the result is 0).
//   sys_clk_pin, reset : clock, synchronous active-high reset
//   inc_i              : advance address
//   clr_i              : force address to 0 next cycle
//   addr_o             : current address
//   wrap_o             : registered pulse, high in the cycle the address
//                        has just wrapped to 0
// ---------------------------------------------------------------------------
module frame_addr_ctr
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEF
) (
    input  logic              sys_clk_pin,
    input  logic              reset,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              wrap_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrap_q;
    logic              at_last;

    assign at_last = (addr_q == LAST);

    always_comb begin
        addr_d = addr_q;
        if (clr_i)
            addr_d = '0;
        else if (inc_i)
            addr_d = at_last ? '0 : addr_q + 1'b1;
    end

    always_ff @(posedge sys_clk_pin) begin
        if (reset) begin
            addr_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            wrap_q <= inc_i && at_last;
        end
    end

    assign addr_o = addr_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Schedules the single frame-buffer BRAM port between the camera capture
// FIFO (writes) and the display FIFO (burst reads). Owns both frame address
// counters, handles frame-start resync, read/write fairness and sticky
// capture-overflow flagging.
//   sys_clk_pin, reset   : 100 MHz clock, synchronous active-high reset
//   cap_*                : capture FIFO (FWFT) side; cap_rd pops the head
//   disp_almost_full     : display FIFO cannot take another RD_BURST words
//   disp_wr/disp_data    : display FIFO push, one cycle after each read
//   ram_*                : BRAM port; ram_dout valid 1 cycle after issue
//   frame_done           : pulse when the read address wraps to 0
//   overflow_err         : sticky, capture FIFO full while not writing
// ---------------------------------------------------------------------------
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int RD_BURST     = RD_BURST_DEF,
    parameter int WR_RUN       = WR_RUN_DEF,
    parameter int STARVE_MAX   = STARVE_MAX_DEF
) (
    input  logic              sys_clk_pin,
    input  logic              reset,
    input  logic              cap_empty,
    input  logic              cap_full,
    input  logic [DATA_W-1:0] cap_data,
    output logic              cap_rd,
    input  logic              cap_frame_start,
    input  logic              disp_almost_full,
    input  logic              disp_frame_start,
    output logic              disp_wr,
    output logic [DATA_W-1:0] disp_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              frame_done,
    output logic              overflow_err
);

    localparam int BEAT_W   = (RD_BURST > 1) ? $clog2(RD_BURST) : 1;
    localparam int RUN_W    = $clog2(WR_RUN + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(RD_BURST - 1);
    localparam logic [RUN_W-1:0]    RUN_MAX   = RUN_W'(WR_RUN);
    localparam logic [STARVE_W-1:0] STV_MAX   = STARVE_W'(STARVE_MAX);

    state_t              state_q;
    logic [STARVE_W-1:0] starve_q;
    logic [RUN_W-1:0]    run_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                disp_pend_q;
    logic                disp_wr_q;
    logic                overflow_q;

    logic              rd_ok, cap_ok;
    logic              rd_grant;
    logic              wr_issue, rd_issue;
    logic              rd_clr;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              rd_wrap;
    logic              wr_wrap_unused;

    assign rd_ok  = !disp_almost_full;
    assign cap_ok = !cap_empty;

    // Reads win unless capture data has already waited STARVE_MAX bursts.
    assign rd_grant = (state_q == IDLE) && rd_ok &&
                      (!cap_ok || (starve_q < STV_MAX));

    // The cycle after the WR_RUN-th word (or an empty FIFO) is a dead exit
    // cycle in WRITE: no RAM access, no pop.
    assign wr_issue = (state_q == WRITE) && cap_ok && (run_q < RUN_MAX);
    assign rd_issue = (state_q == READ);

    // A latched display vsync restarts the frame at the grant decision, so
    // the first issue of the new burst already sees address 0.
    assign rd_clr = rd_grant && disp_pend_q;

    frame_addr_ctr #(
        .ADDR_W      (ADDR_W),
        .FRAME_PIXELS(FRAME_PIXELS)
    ) u_wr_ctr (
        .sys_clk_pin(sys_clk_pin),
        .reset      (reset),
        .inc_i      (wr_issue),
        .clr_i      (cap_frame_start),
        .addr_o     (wr_addr),
        .wrap_o     (wr_wrap_unused)
    );

    frame_addr_ctr #(
        .ADDR_W      (ADDR_W),
        .FRAME_PIXELS(FRAME_PIXELS)
    ) u_rd_ctr (
        .sys_clk_pin(sys_clk_pin),
        .reset      (reset),
        .inc_i      (rd_issue),
        .clr_i      (rd_clr),
        .addr_o     (rd_addr),
        .wrap_o     (rd_wrap)
    );

    always_ff @(posedge sys_clk_pin) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            run_q       <= '0;
            beat_q      <= '0;
            disp_pend_q <= 1'b0;
            disp_wr_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            disp_wr_q <= rd_issue;

            if (cap_full && (state_q != WRITE))
                overflow_q <= 1'b1;

            // A new vsync arriving on the grant cycle stays pending for the
            // following burst.
            if (disp_frame_start)
                disp_pend_q <= 1'b1;
            else if (rd_grant)
                disp_pend_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (rd_grant) begin
                        state_q <= READ;
                        beat_q  <= '0;
                        if (cap_ok && (starve_q != STV_MAX))
                            starve_q <= starve_q + 1'b1;
                    end else if (cap_ok) begin
                        state_q  <= WRITE;
                        run_q    <= '0;
                        starve_q <= '0;
                    end
                end
                WRITE: begin
                    if (wr_issue)
                        run_q <= run_q + 1'b1;
                    else
                        state_q <= IDLE;
                end
                READ: begin
                    // Burst length is fixed; disp_almost_full is not
                    // re-examined once the burst is granted.
                    if (beat_q == LAST_BEAT)
                        state_q <= DRAIN;
                    else
                        beat_q <= beat_q + 1'b1;
                end
                DRAIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cap_rd   = wr_issue;
    assign ram_en   = wr_issue || rd_issue;
    assign ram_we   = wr_issue;
    assign ram_addr = wr_issue ? wr_addr : (rd_issue ? rd_addr : '0);
    assign ram_din  = wr_issue ? cap_data : '0;

    // RAM read data lands in the same cycle as the registered push strobe;
    // gate it so the FIFO data bus is quiet between bursts.
    assign disp_wr      = disp_wr_q;
    assign disp_data    = disp_wr_q ? ram_dout : '0;
    assign frame_done   = rd_wrap;
    assign overflow_err = overflow_q;

endmodule
